// File: rtl/tree_space_mgr_pkg.sv
// Shared types for the BST node-slot allocator.
//   tsm_state_e : allocator FSM states (slot empty / slot valid / clear in progress)
//   idx_width() : width of a node index for a given node count (min 1 bit)
package tree_space_mgr_pkg;

    typedef enum logic [1:0] {
        StFill,
        StReady,
        StClear
    } tsm_state_e;

    function automatic int unsigned idx_width(input int unsigned node_num);
        return (node_num > 1) ? $clog2(node_num) : 1;
    endfunction

endpackage

// File: rtl/tree_space_mgr_fifo.sv
// Synchronous FIFO of recycled node indices.
//   clk_i   : clock
//   srst_i  : synchronous active-high reset
//   flush_i : drop all entries (same effect as reset)
//   push_i  : write data_i at the tail
//   data_i  : index to push
//   pop_i   : advance the head (ignored while empty)
//   data_o  : current head entry
//   empty_o : no entries stored; a push is visible here one cycle later
module tree_space_mgr_fifo #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tree_space_mgr.sv
// Node-slot allocator for the BST engine.
//   aclk_i / srst_i            : clock, synchronous active-high reset
//   tree_clear_i               : pulse, release every node
//   tree_ready_o               : low while a clear is in progress
//   tree_mgt_req_valid_i/ready_o/addr_o : allocation handshake; addr valid while ready
//   tree_mgt_free_valid_i/ready_o/addr_i: release handshake
//   tree_mgt_full_o            : all nodes allocated
//   used_count_o               : number of allocated nodes
//   free_err_o                 : one-cycle pulse after an illegal release was dropped
module tree_space_mgr
    import tree_space_mgr_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned NODE_NUM       = 64,
    parameter int unsigned NODE_STRIDE    = 8,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                          aclk_i,
    input  logic                          srst_i,
    input  logic                          tree_clear_i,
    output logic                          tree_ready_o,
    input  logic                          tree_mgt_req_valid_i,
    output logic                          tree_mgt_req_ready_o,
    output logic [RAM_ADDR_WIDTH-1:0]     tree_mgt_req_addr_o,
    input  logic                          tree_mgt_free_valid_i,
    output logic                          tree_mgt_free_ready_o,
    input  logic [RAM_ADDR_WIDTH-1:0]     tree_mgt_free_addr_i,
    output logic                          tree_mgt_full_o,
    output logic [$clog2(NODE_NUM+1)-1:0] used_count_o,
    output logic                          free_err_o
);

    localparam int unsigned IdxW     = idx_width(NODE_NUM);
    localparam int unsigned UsedW    = $clog2(NODE_NUM + 1);
    localparam int unsigned StrideSh = $clog2(NODE_STRIDE);

    tsm_state_e          state_q, state_d;
    logic [IdxW-1:0]     slot_q, slot_d;
    logic [IdxW:0]       fresh_q, fresh_d;
    logic [NODE_NUM-1:0] bitmap_q, bitmap_d;
    logic [UsedW-1:0]    used_q, used_d;
    logic                free_err_q, free_err_d;

    logic            fifo_empty, fifo_pop;
    logic [IdxW-1:0] fifo_head;

    logic            req_hs, free_hs, free_legal;
    logic [31:0]     free_off;
    logic [IdxW-1:0] free_idx;
    logic            free_aligned, free_in_range;

    // Offset is computed in 32 bits so addresses below BASE_ADDR wrap to a huge value and
    // fail the range check.
    assign free_off      = 32'(tree_mgt_free_addr_i) - 32'(BASE_ADDR);
    assign free_aligned  = ((free_off & 32'(NODE_STRIDE - 1)) == 32'd0);
    assign free_in_range = (free_off < 32'(NODE_NUM * NODE_STRIDE));
    assign free_idx      = IdxW'(free_off >> StrideSh);

    // A pending clear wins over both handshakes, so their effects are suppressed here.
    assign req_hs     = (state_q == StReady) & tree_mgt_req_valid_i & ~tree_clear_i;
    assign free_hs    = tree_mgt_free_ready_o & tree_mgt_free_valid_i & ~tree_clear_i;
    assign free_legal = free_hs & free_aligned & free_in_range & bitmap_q[free_idx];
    assign fifo_pop   = (state_q == StFill) & ~fifo_empty & ~tree_clear_i;

    tree_space_mgr_fifo #(
        .Depth (NODE_NUM),
        .Width (IdxW)
    ) u_fifo (
        .clk_i   (aclk_i),
        .srst_i  (srst_i),
        .flush_i (tree_clear_i),
        .push_i  (free_legal),
        .data_i  (free_idx),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        fresh_d    = fresh_q;
        bitmap_d   = bitmap_q;
        used_d     = used_q;
        free_err_d = free_hs & ~free_legal;

        unique case (state_q)
            StFill: begin
                // Recycled indices first; the fresh counter saturates at NODE_NUM.
                if (fifo_pop) begin
                    slot_d  = fifo_head;
                    state_d = StReady;
                end else if (fresh_q < (IdxW+1)'(NODE_NUM)) begin
                    slot_d  = fresh_q[IdxW-1:0];
                    fresh_d = fresh_q + (IdxW+1)'(1);
                    state_d = StReady;
                end
            end
            StReady: begin
                if (req_hs) begin
                    bitmap_d[slot_q] = 1'b1;
                    state_d          = StFill;
                end
            end
            StClear: state_d = StFill;
            default: state_d = StFill;
        endcase

        // The slot index is never marked in the bitmap, so it cannot collide with free_idx.
        if (free_legal) begin
            bitmap_d[free_idx] = 1'b0;
        end

        unique case ({req_hs, free_legal})
            2'b10:   used_d = used_q + UsedW'(1);
            2'b01:   used_d = used_q - UsedW'(1);
            default: used_d = used_q;
        endcase

        if (tree_clear_i) begin
            state_d    = StClear;
            fresh_d    = '0;
            bitmap_d   = '0;
            used_d     = '0;
            free_err_d = 1'b0;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (srst_i) begin
            state_q    <= StFill;
            slot_q     <= '0;
            fresh_q    <= '0;
            bitmap_q   <= '0;
            used_q     <= '0;
            free_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            fresh_q    <= fresh_d;
            bitmap_q   <= bitmap_d;
            used_q     <= used_d;
            free_err_q <= free_err_d;
        end
    end

    assign tree_ready_o          = (state_q != StClear);
    assign tree_mgt_free_ready_o = (state_q != StClear);
    assign tree_mgt_req_ready_o  = (state_q == StReady);
    assign tree_mgt_req_addr_o   = tree_mgt_req_ready_o
                                 ? RAM_ADDR_WIDTH'(BASE_ADDR)
                                   + (RAM_ADDR_WIDTH'(slot_q) << StrideSh)
                                 : '0;
    assign tree_mgt_full_o       = (used_q == UsedW'(NODE_NUM));
    assign used_count_o          = used_q;
    assign free_err_o            = free_err_q;

endmodule

// File: tb/tb_tree_space_mgr.sv
module tb_tree_space_mgr;

    localparam int unsigned AW = 16;
    localparam int unsigned NN = 4;
    localparam int unsigned ST = 8;
    localparam int unsigned BA = 'h100;
    localparam int unsigned UW = $clog2(NN + 1);

    logic          aclk = 1'b0;
    logic          rst, clr, rv, fv;
    logic [AW-1:0] fa;
    logic          tree_ready, req_ready, free_ready, full, free_err;
    logic [AW-1:0] req_addr;
    logic [UW-1:0] used;

    always #5 aclk = ~aclk;

    tree_space_mgr #(
        .RAM_ADDR_WIDTH (AW),
        .NODE_NUM       (NN),
        .NODE_STRIDE    (ST),
        .BASE_ADDR      (BA)
    ) dut (
        .aclk_i                (aclk),
        .srst_i                (rst),
        .tree_clear_i          (clr),
        .tree_ready_o          (tree_ready),
        .tree_mgt_req_valid_i  (rv),
        .tree_mgt_req_ready_o  (req_ready),
        .tree_mgt_req_addr_o   (req_addr),
        .tree_mgt_free_valid_i (fv),
        .tree_mgt_free_ready_o (free_ready),
        .tree_mgt_free_addr_i  (fa),
        .tree_mgt_full_o       (full),
        .used_count_o          (used),
        .free_err_o            (free_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int grants[$];
    int grant_cyc[$];

    // Behavioural model: set of allocated indices, queue of recycled indices, fresh counter,
    // and a one-entry slot that needs one empty cycle to be refilled.
    bit alloc_m[NN];
    int recyc_m[$];
    int fresh_m;
    bit slot_full_m;
    int slot_m;
    bit clear_m;
    bit err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (alloc_m[i]) alloc_m[i] = 1'b0;
        recyc_m.delete();
        fresh_m     = 0;
        slot_full_m = 1'b0;
        slot_m      = 0;
        clear_m     = 1'b0;
        err_m       = 1'b0;
    endfunction

    function automatic int model_used();
        int n = 0;
        foreach (alloc_m[i]) n += int'(alloc_m[i]);
        return n;
    endfunction

    function automatic void model_step();
        bit accepted, legal;
        int off, idx;
        if (rst) begin
            model_reset();
            return;
        end
        if (clr) begin
            foreach (alloc_m[i]) alloc_m[i] = 1'b0;
            recyc_m.delete();
            fresh_m     = 0;
            slot_full_m = 1'b0;
            clear_m     = 1'b1;
            err_m       = 1'b0;
            return;
        end
        accepted = fv && !clear_m;
        legal    = 1'b0;
        idx      = 0;
        if (accepted) begin
            off = int'(fa) - int'(BA);
            if (off >= 0 && off % ST == 0 && off / ST < NN) begin
                idx   = off / ST;
                legal = alloc_m[idx];
            end
        end
        if (clear_m) begin
            clear_m = 1'b0;
        end else if (slot_full_m) begin
            if (rv) begin
                alloc_m[slot_m] = 1'b1;
                slot_full_m     = 1'b0;
            end
        end else if (recyc_m.size() > 0) begin
            slot_m      = recyc_m.pop_front();
            slot_full_m = 1'b1;
        end else if (fresh_m < NN) begin
            slot_m      = fresh_m;
            fresh_m++;
            slot_full_m = 1'b1;
        end
        if (legal) begin
            alloc_m[idx] = 1'b0;
            recyc_m.push_back(idx);
        end
        err_m = accepted && !legal;
    endfunction

    // Compare every output with the model, then apply the current inputs for one clock.
    task automatic cycle();
        int exp_addr;
        exp_addr = slot_full_m ? int'(BA) + slot_m * ST : 0;
        check("tree_ready", tree_ready, !clear_m);
        check("req_ready", req_ready, slot_full_m);
        check("req_addr", req_addr, exp_addr);
        check("free_ready", free_ready, !clear_m);
        check("used_count", used, model_used());
        check("full", full, model_used() == NN);
        check("free_err", free_err, err_m);
        if (req_ready === 1'b1 && rv && !clr && !rst) begin
            grants.push_back(int'(req_addr));
            grant_cyc.push_back(cyc);
        end
        model_step();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        rv = 1'b0; fv = 1'b0; clr = 1'b0; rst = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        rv = 1'b0; fv = 1'b0; fa = '0; clr = 1'b0; rst = 1'b1;
        @(posedge aclk);
        #1;
        model_reset();
        cycle();
        rst = 1'b0;

        // Reset state
        check("rst_tree_ready", tree_ready, 1);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_used", used, 0);
        check("rst_full", full, 0);
        check("rst_free_err", free_err, 0);

        // 1: four back-to-back allocations, two cycles apart
        grants.delete(); grant_cyc.delete();
        rv = 1'b1;
        repeat (9) cycle();
        rv = 1'b0;
        check("t1_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_grant_addr", grants[i], 'h100 + 8 * i);
        end
        for (int i = 0; i < 3; i++) begin
            check("t1_grant_spacing", grant_cyc[i+1] - grant_cyc[i], 2);
        end
        check("t1_full", full, 1);
        check("t1_used", used, 4);
        check("t1_req_ready", req_ready, 0);

        // 2: release from full, recycled index is handed out next
        fv = 1'b1; fa = 'h108;
        cycle();
        fv = 1'b0;
        check("t2_used", used, 3);
        check("t2_full", full, 0);
        grants.delete();
        rv = 1'b1;
        repeat (4) cycle();
        rv = 1'b0;
        check("t2_grant_count", grants.size(), 1);
        check("t2_grant_addr", grants[0], 'h108);

        // 3: double free, unaligned and out-of-range releases
        fv = 1'b1; fa = 'h108;
        cycle();
        check("t3_free_ready", free_ready, 1);
        cycle();
        check("t3_double_err", free_err, 1);
        check("t3_double_used", used, 3);
        fa = 'h10C;
        cycle();
        check("t3_unaligned_err", free_err, 1);
        fa = 'h120;
        cycle();
        check("t3_range_err", free_err, 1);
        fv = 1'b0;
        cycle();
        check("t3_err_pulse", free_err, 0);

        // 4: same-cycle allocation and release
        idle(2);
        check("t4_slot_addr", req_addr, 'h108);
        rv = 1'b1; fv = 1'b1; fa = 'h100;
        cycle();
        rv = 1'b0; fv = 1'b0;
        check("t4_used", used, 3);
        cycle();
        check("t4_next_ready", req_ready, 1);
        check("t4_next_addr", req_addr, 'h100);

        // 5: clear while a request is pending
        rv = 1'b1; clr = 1'b1;
        cycle();
        rv = 1'b0; clr = 1'b0;
        check("t5_tree_ready", tree_ready, 0);
        check("t5_req_ready", req_ready, 0);
        check("t5_free_ready", free_ready, 0);
        check("t5_used", used, 0);
        cycle();
        check("t5_tree_ready_back", tree_ready, 1);
        grants.delete();
        rv = 1'b1;
        repeat (3) cycle();
        rv = 1'b0;
        check("t5_grant_count", grants.size(), 1);
        check("t5_grant_addr", grants[0], 'h100);
        check("t5_used_after", used, 1);

        // 6: reset in FILL with two recycled entries queued
        rv = 1'b1;
        cycle();
        cycle();
        rv = 1'b0;
        fv = 1'b1; fa = 'h100;
        cycle();
        fa = 'h108;
        cycle();
        fv = 1'b0;
        rv = 1'b1;
        cycle();
        rv = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_tree_ready", tree_ready, 1);
        check("t6_req_ready", req_ready, 0);
        check("t6_req_addr", req_addr, 0);
        check("t6_used", used, 0);
        check("t6_full", full, 0);
        check("t6_free_err", free_err, 0);
        grants.delete();
        rv = 1'b1;
        repeat (4) cycle();
        rv = 1'b0;
        check("t6_grant_count", grants.size(), 2);
        check("t6_grant0", grants[0], 'h100);
        check("t6_grant1", grants[1], 'h108);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            int sel, k;
            rv  = ($urandom_range(0, 99) < 60);
            fv  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 199) < 1);
            sel = $urandom_range(0, 3);
            k   = $urandom_range(0, NN + 1);
            if (sel < 2) begin
                fa = AW'(BA + k * ST);
            end else if (sel == 2) begin
                fa = AW'(BA + k * ST + $urandom_range(1, ST - 1));
            end else begin
                fa = AW'($urandom_range(0, 16'hffff));
            end
            cycle();
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
